// File: rtl/sipo_receiver_if.sv
// Serial link bundle between a bit-serial transmitter and the SIPO receiver.
// The receiver takes the slave side.
interface sipo_receiver_if #(
  parameter int WIDTH = 4
);
  logic             s;
  logic             v;
  logic             w;
  logic [WIDTH-1:0] Q;
  logic             done;
  logic             busy;
  logic             ovr;

  modport master (
    output s, v, w,
    input  Q, done, busy, ovr
  );

  modport slave (
    input  s, v, w,
    output Q, done, busy, ovr
  );
endinterface

// File: rtl/sipo_receiver.sv
// Serial-in/parallel-out receiver: gathers WIDTH qualified bits, LSB first,
// and publishes the word on Q together with a one-cycle done strobe.
module sipo_receiver #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input logic           clk,
  input logic           rst,
  sipo_receiver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // A start strobe always wins, so a frame can be restarted from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.s) state_d = SHIFT;
      SHIFT: begin
        if (bus.s) begin
          state_d = SHIFT;
        end else if (bus.v && (cnt_q == LastBit)) begin
          state_d = DONE;
        end
      end
      DONE:  state_d = bus.s ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Q and done load on the edge that takes the final bit, so both are
  // visible together during the DONE cycle.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    done_d = 1'b0;
    ovr_d  = ovr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.s) begin
          sh_d  = '0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        if (bus.s) begin
          sh_d  = '0;
          cnt_d = '0;
          ovr_d = 1'b1;
        end else if (bus.v) begin
          sh_d  = {bus.w, sh_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LastBit) begin
            q_d    = {bus.w, sh_q[WIDTH-1:1]};
            done_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      default: begin
        sh_d  = '0;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
  end

  assign bus.Q    = q_q;
  assign bus.done = done_q;
  assign bus.busy = busy;
  assign bus.ovr  = ovr_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Bench for sipo_receiver: directed frames from the test plan, then random
// traffic, all compared each cycle against a queue-based reference model.
module tb_sipo_receiver;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sipo_receiver_if #(.WIDTH(WIDTH)) bus ();

  sipo_receiver #(.WIDTH(WIDTH), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is "open" after a start, bits are queued as
  // they arrive and the word is assembled arithmetically once WIDTH are in.
  bit             mOpen;
  bit             mBits[$];
  logic [WIDTH-1:0] mQ;
  logic           mDone;
  logic           mOvr;

  task automatic modelStep(input logic r, input logic s, input logic v, input logic w);
    int word;
    if (r) begin
      mOpen = 0;
      mBits.delete();
      mQ    = '0;
      mDone = 1'b0;
      mOvr  = 1'b0;
    end else begin
      mDone = 1'b0;
      if (s) begin
        if (mOpen) mOvr = 1'b1;
        mOpen = 1;
        mBits.delete();
      end else if (mOpen && v) begin
        mBits.push_back(w);
        if (mBits.size() == WIDTH) begin
          word = 0;
          for (int i = 0; i < WIDTH; i++) word += int'(mBits[i]) * (1 << i);
          mQ    = WIDTH'(word);
          mDone = 1'b1;
          mOpen = 0;
          mBits.delete();
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, advance the model on the
  // rising edge, then compare every output just after it.
  task automatic applyStimulus(input logic r, input logic s, input logic v, input logic w);
    @(negedge clk);
    rst   = r;
    bus.s = s;
    bus.v = v;
    bus.w = w;
    @(posedge clk);
    modelStep(r, s, v, w);
    #1;
    checkOutput("Q",    32'(bus.Q),    32'(mQ));
    checkOutput("done", 32'(bus.done), 32'(mDone));
    checkOutput("busy", 32'(bus.busy), 32'(mOpen));
    checkOutput("ovr",  32'(bus.ovr),  32'(mOvr));
  endtask

  task automatic sendBits(input logic [WIDTH-1:0] bits);
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, bits[i]);
  endtask

  int doneCount;
  int busyCount;

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    bus.s = 1'b0;
    bus.v = 1'b0;
    bus.w = 1'b0;
    mOpen = 0;
    mQ    = '0;
    mDone = 1'b0;
    mOvr  = 1'b0;

    // Reset, then a basic frame 1,1,0,0
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_Q", 32'(bus.Q), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    busyCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    if (bus.busy) busyCount++;
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, (i < 2) ? 1'b1 : 1'b0);
      if (bus.busy) busyCount++;
    end
    checkOutput("t1_done", 32'(bus.done), 32'h1);
    checkOutput("t1_Q", 32'(bus.Q), 32'h3);
    checkOutput("t1_busy_cycles", 32'(busyCount), 32'(WIDTH));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_done_once", 32'(bus.done), 32'h0);
    checkOutput("t1_ovr", 32'(bus.ovr), 32'h0);

    // Bit gaps: 1,1,1,1 with three idle cycles between bits
    doneCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      if (bus.done) doneCount++;
      if (i < WIDTH - 1) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
          if (bus.done) doneCount++;
          checkOutput("t2_gap_Q", 32'(bus.Q), 32'h3);
        end
      end
    end
    checkOutput("t2_Q", 32'(bus.Q), 32'hF);
    checkOutput("t2_done_count", 32'(doneCount), 32'h1);

    // Back-to-back frames, second start in the DONE cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(4'b0101);
    checkOutput("t3_Q_first", 32'(bus.Q), 32'h5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_restart_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'b0, 1'b0, 1'b1, (i == 0) ? 1'b1 : 1'b0);
    checkOutput("t3_not_yet", 32'(bus.done), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t3_done_6_later", 32'(bus.done), 32'h1);
    checkOutput("t3_Q_second", 32'(bus.Q), 32'h9);
    checkOutput("t3_ovr", 32'(bus.ovr), 32'h0);

    // Restart mid-frame: s, 1,0, s, 0,1,1,0
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_ovr_set", 32'(bus.ovr), 32'h1);
    sendBits(4'b0110);
    checkOutput("t4_Q", 32'(bus.Q), 32'h6);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(4'b1010);
    checkOutput("t4_ovr_sticky", 32'(bus.ovr), 32'h1);

    // Reset mid-frame, then a clean frame 1,0,1,1
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(4'b0011);
    checkOutput("t5_Q_before", 32'(bus.Q), 32'h3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_Q_cleared", 32'(bus.Q), 32'h0);
    checkOutput("t5_busy", 32'(bus.busy), 32'h0);
    doneCount = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      if (bus.done) doneCount++;
    end
    checkOutput("t5_no_done", 32'(doneCount), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(4'b1101);
    checkOutput("t5_Q_after", 32'(bus.Q), 32'hD);

    // Ignore-when-idle after a fresh reset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'(i % 2), 1'($urandom_range(0, 1)));
    end
    checkOutput("t6_Q", 32'(bus.Q), 32'h0);
    checkOutput("t6_busy", 32'(bus.busy), 32'h0);
    checkOutput("t6_done", 32'(bus.done), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 14) == 0),
                    1'($urandom_range(0, 99) < 70),
                    1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
